// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, default latencies and shared types for the multiply/divide unit.
package mdu_pkg;

    localparam int unsigned OP_W            = 3;
    localparam int unsigned XLEN            = 32;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    localparam logic [OP_W-1:0] MDU_MULT  = 3'd0;
    localparam logic [OP_W-1:0] MDU_MULTU = 3'd1;
    localparam logic [OP_W-1:0] MDU_DIV   = 3'd2;
    localparam logic [OP_W-1:0] MDU_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] MDU_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] MDU_MTLO  = 3'd5;

    // Result waiting for commit; a divide by zero commits nothing.
    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        logic            dbz;
    } mdu_res_t;

    // True for the multi-cycle ops (mult/multu/div/divu).
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // True for the divide ops.
    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: issue/result bundle between the execute stage and the MDU.
//   start/op/rs_val/rt_val : issue side (driven by master)
//   busy/done/hi/lo        : status and architectural HI/LO (driven by slave)
interface mdu_if;
    import mdu_pkg::*;

    logic            start;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply / divide datapath.
//   op          : operation select (only mult/multu/div/divu produce a result)
//   rs_val      : multiplicand / dividend
//   rt_val      : multiplier / divisor
//   res_hi      : product high word or remainder
//   res_lo      : product low word or quotient
//   div_by_zero : divide op with rt_val == 0
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo,
    output logic            div_by_zero
);

    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_u;
    logic [XLEN-1:0]   rt_safe;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   q_mag;
    logic [XLEN-1:0]   r_mag;
    logic [XLEN-1:0]   q_s;
    logic [XLEN-1:0]   r_s;
    logic [XLEN-1:0]   q_u;
    logic [XLEN-1:0]   r_u;

    // Products: the low 64 bits of a product of sign-extended operands is the signed product.
    always_comb begin
        prod_s = {{XLEN{rs_val[XLEN-1]}}, rs_val} * {{XLEN{rt_val[XLEN-1]}}, rt_val};
        prod_u = {{XLEN{1'b0}}, rs_val} * {{XLEN{1'b0}}, rt_val};
    end

    // Divides on magnitudes; zero divisor is steered to 1 so the datapath never sees /0.
    // -0x80000000 as an unsigned magnitude is 0x80000000, which makes the overflow case
    // fall out naturally as lo = 0x80000000, hi = 0.
    always_comb begin
        div_by_zero = is_div(op) && (rt_val == '0);
        rt_safe     = (rt_val == '0) ? XLEN'(1) : rt_val;
        a_neg       = rs_val[XLEN-1];
        b_neg       = rt_safe[XLEN-1];
        a_mag       = a_neg ? (~rs_val + XLEN'(1)) : rs_val;
        b_mag       = b_neg ? (~rt_safe + XLEN'(1)) : rt_safe;
        q_mag       = a_mag / b_mag;
        r_mag       = a_mag % b_mag;
        q_s         = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
        r_s         = a_neg ? (~r_mag + XLEN'(1)) : r_mag;
        q_u         = rs_val / rt_safe;
        r_u         = rs_val % rt_safe;
    end

    // Result select.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV:   begin res_hi = r_s; res_lo = q_s; end
            MDU_DIVU:  begin res_hi = r_u; res_lo = q_u; end
            default:   begin res_hi = '0;  res_lo = '0;  end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mdu_if.slave (start/op/rs_val/rt_val in; busy/done/hi/lo out)
// The result is computed at issue and held in a pending register; the cycle
// counter only models the fixed MULT_CYCLES / DIV_CYCLES latency.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    mdu_res_t          pend_q,  pend_d;
    logic [XLEN-1:0]   hi_q,    hi_d;
    logic [XLEN-1:0]   lo_q,    lo_d;
    logic              done_q,  done_d;

    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;
    logic              res_dbz;

    mdu_arith u_arith (
        .op          (bus.op),
        .rs_val      (bus.rs_val),
        .rt_val      (bus.rt_val),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (res_dbz)
    );

    // State and architectural registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Issue, countdown and commit.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (is_muldiv(bus.op)) begin
                        pend_d  = '{hi: res_hi, lo: res_lo, dbz: res_dbz};
                        count_d = is_div(bus.op) ? CNT_W'(DIV_CYCLES - 1)
                                                 : CNT_W'(MULT_CYCLES - 1);
                        state_d = S_BUSY;
                    end else if (bus.op == MDU_MTHI) begin
                        hi_d = bus.rs_val;
                    end else if (bus.op == MDU_MTLO) begin
                        lo_d = bus.rs_val;
                    end
                end
            end
            S_BUSY: begin
                // start is ignored here, including on the commit edge.
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    if (!pend_q.dbz) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q == S_BUSY);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed table, hand-written corner sequences and random ops
// checked against an integer-arithmetic model of HI/LO and latency.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    mdu_if bus ();

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] rs, rt, hi, lo);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.hi = hi; v.lo = lo;
        return v;
    endfunction

    function automatic int latency(input logic [2:0] op);
        if (op <= 3'd1) return MULT_N;
        if (op <= 3'd3) return DIV_N;
        return 0;
    endfunction

    // Reference: plain 64-bit integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] rs, rt,
                                  input logic [31:0] hi_in, lo_in,
                                  output logic [31:0] hi_o, output logic [31:0] lo_o);
        longint          a, b, q, r;
        longint unsigned pu;
        hi_o = hi_in;
        lo_o = lo_in;
        case (op)
            3'd0: begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                q = a * b;
                hi_o = q[63:32]; lo_o = q[31:0];
            end
            3'd1: begin
                pu = longint'({32'd0, rs}) * longint'({32'd0, rt});
                hi_o = pu[63:32]; lo_o = pu[31:0];
            end
            3'd2: if (rt != 0) begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                q = a / b;
                r = a % b;
                hi_o = r[31:0]; lo_o = q[31:0];
            end
            3'd3: if (rt != 0) begin
                hi_o = rs % rt; lo_o = rs / rt;
            end
            3'd4: hi_o = rs;
            3'd5: lo_o = rs;
            default: ;
        endcase
    endfunction

    // Issue one op at a falling edge and follow it to completion.
    task automatic do_op(input logic [2:0] op, input logic [31:0] rs, rt,
                         input logic [31:0] exp_hi, exp_lo, input string tag);
        int n_exp;
        int cyc;
        n_exp = latency(op);
        bus.start = 1'b1; bus.op = op; bus.rs_val = rs; bus.rt_val = rt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            chk({tag, " done_low_while_busy"}, 64'(bus.done), 64'd0);
            chk({tag, " hi_held"}, 64'(bus.hi), 64'(hi_m));
            chk({tag, " lo_held"}, 64'(bus.lo), 64'(lo_m));
            cyc++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(cyc), 64'(n_exp));
        chk({tag, " done"}, 64'(bus.done), (n_exp != 0) ? 64'd1 : 64'd0);
        chk({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        hi_m = exp_hi;
        lo_m = exp_lo;
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [31:0] eh, el, rs, rt;
        logic [2:0]  op;
        int cyc;

        vecs.push_back(mk(3'd0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE));
        vecs.push_back(mk(3'd1, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE));
        vecs.push_back(mk(3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk(3'd3, 32'h7,        32'h2,        32'h00000001, 32'h00000003));
        vecs.push_back(mk(3'd4, 32'h11111111, 32'h0,        32'h11111111, 32'h00000003));
        vecs.push_back(mk(3'd5, 32'h22222222, 32'h0,        32'h11111111, 32'h22222222));
        vecs.push_back(mk(3'd2, 32'h12345678, 32'h0,        32'h11111111, 32'h22222222));
        vecs.push_back(mk(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000));
        vecs.push_back(mk(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000));
        vecs.push_back(mk(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001));
        vecs.push_back(mk(3'd0, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB));
        vecs.push_back(mk(3'd2, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD));
        vecs.push_back(mk(3'd3, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF));
        vecs.push_back(mk(3'd6, 32'hAAAAAAAA, 32'h1,        32'h0000000F, 32'h0FFFFFFF));
        vecs.push_back(mk(3'd7, 32'hBBBBBBBB, 32'h1,        32'h0000000F, 32'h0FFFFFFF));
        vecs.push_back(mk(3'd3, 32'h5,        32'h0,        32'h0000000F, 32'h0FFFFFFF));

        // Reset state.
        reset = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0;
        repeat (2) @(negedge clk);
        chk("reset hi",   64'(bus.hi),   64'd0);
        chk("reset lo",   64'(bus.lo),   64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed table.
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo,
                  $sformatf("vec%0d", i));
        end

        // Issue while busy: mthi and div on busy cycles 2 and 3 are dropped.
        bus.start = 1'b1; bus.op = 3'd0; bus.rs_val = 32'd3; bus.rt_val = 32'hFFFFFFFB;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.rs_val = 32'hDEADBEEF;
        @(negedge clk);
        bus.op = 3'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 3;
        while (bus.busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("ibusy busy_cycles", 64'(cyc), 64'(MULT_N));
        chk("ibusy done", 64'(bus.done), 64'd1);
        chk("ibusy hi", 64'(bus.hi), 64'hFFFFFFFF);
        chk("ibusy lo", 64'(bus.lo), 64'hFFFFFFF1);
        @(negedge clk);
        chk("ibusy no_second_issue", 64'(bus.busy), 64'd0);
        hi_m = 32'hFFFFFFFF; lo_m = 32'hFFFFFFF1;

        // start held across the commit edge: next op is taken one edge later.
        bus.start = 1'b1; bus.op = 3'd1; bus.rs_val = 32'd6; bus.rt_val = 32'd7;
        @(posedge clk); #1;
        bus.op = 3'd5; bus.rs_val = 32'hAA;
        @(negedge clk);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("b2b busy_cycles", 64'(cyc), 64'(MULT_N));
        chk("b2b lo_at_commit", 64'(bus.lo), 64'd42);
        chk("b2b hi_at_commit", 64'(bus.hi), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b lo_after", 64'(bus.lo), 64'hAA);
        chk("b2b busy_after", 64'(bus.busy), 64'd0);
        hi_m = 32'd0; lo_m = 32'hAA;

        // Reset mid-divide: asynchronous clear, no done afterwards.
        bus.start = 1'b1; bus.op = 3'd2; bus.rs_val = 32'd1000; bus.rt_val = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst busy_async", 64'(bus.busy), 64'd0);
        chk("rst hi_async",   64'(bus.hi),   64'd0);
        chk("rst lo_async",   64'(bus.lo),   64'd0);
        #2;
        reset = 1'b1;
        cyc = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) cyc++;
        end
        chk("rst no_done_or_busy", 64'(cyc), 64'd0);
        hi_m = '0; lo_m = '0;
        do_op(3'd5, 32'd5, 32'd0, 32'd0, 32'd5, "rst mtlo");

        // Random ops against the model.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            rs = $urandom;
            case ($urandom_range(0, 3))
                0:       rt = 32'd0;
                1:       rt = 32'($urandom_range(1, 16));
                2:       rt = -32'($urandom_range(1, 16));
                default: rt = $urandom;
            endcase
            model(op, rs, rt, hi_m, lo_m, eh, el);
            do_op(op, rs, rt, eh, el, $sformatf("rnd%0d op%0d", i, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the execute stage, alongside the ALU.
- Takes the two GRF read values (rs, rt) and the decoded operation.
- Produces the architectural HI/LO registers and a busy flag, which the controller/hazard logic uses to stall mfhi/mflo and further MDU ops.
- Models the fixed MIPS latencies: mult/multu take MULT_CYCLES, div/divu take DIV_CYCLES; mthi/mtlo complete in one cycle.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  issue strobe for op; sampled at the rising edge.
- op  in  3  0 = mult, 1 = multu, 2 = div, 3 = divu, 4 = mthi, 5 = mtlo; 6 and 7 are no-ops.
- rs_val  in  32  operand A (dividend/multiplicand, or mthi/mtlo data).
- rt_val  in  32  operand B (divisor/multiplier).
- busy  out  1  high while a mult/div is in flight.
- done  out  1  one-cycle pulse in the cycle after a mult/div commits.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: reset = 0 asynchronously forces hi = 0, lo = 0, busy = 0, done = 0, count = 0 and clears the pending result. This applies even mid-operation; the in-flight result is discarded.
- Issue: an op is accepted at edge E0 only if start = 1 and busy = 0.
  - start while busy = 1 is ignored entirely; upstream must stall.
  - op 6 or 7 with start = 1 is ignored.
- mult/multu/div/divu at E0:
  - The 64-bit result is computed from rs_val/rt_val and latched into pending registers.
  - busy becomes 1 after E0; count is loaded with N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - On each later edge, if count != 0 then count decrements.
  - On the edge where count == 0, pending is committed to hi/lo, busy goes to 0, and done goes to 1 for exactly one cycle.
  - busy is therefore high for exactly N cycles. hi/lo keep their old values until the commit edge.
- mthi/mtlo at E0:
  - hi (resp. lo) is set to rs_val at E0; the other register is untouched.
  - busy stays 0 and done stays 0.
- Arithmetic:
  - mult: signed 32x32 -> 64, {hi, lo} = product.
  - multu: unsigned 32x32 -> 64.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - div, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - divu: unsigned quotient/remainder.
- Divide by zero (div or divu with rt_val = 0):
  - The op is still accepted and busy runs the full DIV_CYCLES.
  - On commit, hi and lo are left unchanged; done still pulses.
- Back-to-back: a new start is accepted on the same edge where busy falls? No. That edge still sees busy = 1, so the earliest next issue is the following edge.
- done is registered and is never asserted while busy = 1.

Decomposition:
- Package mdu_pkg holds:
  - op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO).
  - default cycle-count constants.
  - an is_muldiv(op) helper.
- One sub-module, mdu_arith: purely combinational. It takes op, rs_val and rt_val and returns res_hi, res_lo and div_by_zero.
- Sequencing (count, busy, done, commit) stays in mdu.

Test Plan:
- Signed mult: start, op = 0, rs = 0xFFFFFFFF, rt = 0x00000002 -> busy high for 5 cycles, hi/lo unchanged until commit, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE, done pulses 1 cycle.
- Unsigned mult: op = 1, same operands -> hi = 0x00000001, lo = 0xFFFFFFFE.
- Signed/unsigned div:
  - op = 2, rs = 0xFFFFFFF9 (-7), rt = 2 -> busy 10 cycles, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - op = 3, rs = 7, rt = 2 -> lo = 3, hi = 1.
- Divide by zero: preload hi = 0x11111111 and lo = 0x22222222 via mthi/mtlo, then op = 2 with rt = 0 -> busy 10 cycles, done pulses, hi/lo still 0x11111111/0x22222222.
- Issue while busy: start a mult, then assert start with op = 4 (mthi, rs = 0xDEADBEEF) and op = 2 on busy cycles 2 and 3 -> both ignored. The final hi/lo equal the mult result, and busy drops on schedule.
- Reset mid-op: start div, drive reset = 0 for half a cycle at busy cycle 4 -> hi = lo = 0 and busy = 0 immediately (asynchronously), no done pulse follows. A subsequent op = 5 with rs = 5 gives lo = 5.
